// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the CPU control unit and a 256x32 word-addressed data RAM.
// Breaks each request into single-cycle RAM accesses and handles lane extraction and sub-word read-modify-write.
module data_mem_ctrl #(
    parameter int RAM_WORDS = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        ReadWrite,
    input  logic [1:0]  DataSize,
    input  logic        Signed,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [31:0] DataInHi,
    output logic [31:0] DataOut,
    output logic [31:0] DataOutHi,
    output logic        MOC,
    output logic        Fault,
    output logic        Busy,
    output logic        RamEnable,
    output logic        RamReadWrite,
    output logic [7:0]  RamAddress,
    output logic [31:0] RamWrData,
    input  logic [31:0] RamRdData
);

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD1,
        CAP,
        RMW_RD,
        RMW_MRG,
        WR0,
        WR1,
        DONE
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    localparam logic [7:0] LAST_IDX = 8'(RAM_WORDS - 1);

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] dout_hi_q, dout_hi_d;
    logic        fault_q, fault_d;

    logic        misalign;
    logic        req_fault;
    logic [4:0]  shamt;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    logic        ram_en;
    logic        ram_wr;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;

    // Request screening is done on the raw inputs so a rejected request never reaches the RAM.
    always_comb begin
        misalign = 1'b0;
        case (DataSize)
            SZ_H:       misalign = Address[0];
            SZ_W, SZ_D: misalign = (Address[1:0] != 2'b00);
            default:    misalign = 1'b0;
        endcase
        req_fault = misalign
                 || (Address[31:10] != 22'd0)
                 || ((DataSize == SZ_D) && (Address[9:2] == LAST_IDX));
    end

    always_comb begin
        shamt    = {lane_q, 3'b000};
        rd_shift = RamRdData >> shamt;
        case (size_q)
            SZ_B:    load_ext = sgn_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                      : {24'h000000, rd_shift[7:0]};
            SZ_H:    load_ext = sgn_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                      : {16'h0000, rd_shift[15:0]};
            default: load_ext = RamRdData;
        endcase
        lane_mask = ((size_q == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
        merged    = (RamRdData & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        lane_d     = lane_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wdata_hi_d = wdata_hi_q;
        dout_d     = dout_q;
        dout_hi_d  = dout_hi_q;
        fault_d    = fault_q;

        case (state_q)
            IDLE: begin
                if (MFA) begin
                    rw_d       = ReadWrite;
                    size_d     = DataSize;
                    sgn_d      = Signed;
                    lane_d     = Address[1:0];
                    idx_d      = Address[9:2];
                    wdata_d    = DataIn;
                    wdata_hi_d = DataInHi;
                    fault_d    = req_fault;
                    if (req_fault) begin
                        state_d = DONE;
                    end else if (ReadWrite) begin
                        state_d = (DataSize[1] == 1'b0) ? RMW_RD : WR0;
                    end else begin
                        state_d = RD0;
                    end
                end
            end
            RD0: state_d = (size_q == SZ_D) ? RD1 : CAP;
            RD1: begin
                dout_d  = RamRdData;
                state_d = CAP;
            end
            CAP: begin
                if (size_q == SZ_D) begin
                    dout_hi_d = RamRdData;
                end else begin
                    dout_d = load_ext;
                end
                state_d = DONE;
            end
            RMW_RD: state_d = RMW_MRG;
            RMW_MRG: begin
                wdata_d = merged;
                state_d = WR0;
            end
            WR0:  state_d = (size_q == SZ_D) ? WR1 : DONE;
            WR1:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            lane_q     <= 2'b00;
            idx_q      <= 8'd0;
            wdata_q    <= 32'd0;
            wdata_hi_q <= 32'd0;
            dout_q     <= 32'd0;
            dout_hi_q  <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            lane_q     <= lane_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wdata_hi_q <= wdata_hi_d;
            dout_q     <= dout_d;
            dout_hi_q  <= dout_hi_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = 8'd0;
        ram_wdata = 32'd0;
        case (state_q)
            RD0, RMW_RD: begin
                ram_en   = 1'b1;
                ram_addr = idx_q;
            end
            RD1: begin
                ram_en   = 1'b1;
                ram_addr = idx_q + 8'd1;
            end
            WR0: begin
                ram_en    = 1'b1;
                ram_wr    = 1'b1;
                ram_addr  = idx_q;
                ram_wdata = wdata_q;
            end
            WR1: begin
                ram_en    = 1'b1;
                ram_wr    = 1'b1;
                ram_addr  = idx_q + 8'd1;
                ram_wdata = wdata_hi_q;
            end
            default: ram_en = 1'b0;
        endcase
    end

    // Enable is gated by the live reset so nothing is written in the cycle reset is asserted.
    assign RamEnable    = ram_en & Reset;
    assign RamReadWrite = ram_wr;
    assign RamAddress   = ram_addr;
    assign RamWrData    = ram_wdata;

    assign DataOut   = dout_q;
    assign DataOutHi = dout_hi_q;
    assign MOC       = (state_q == DONE);
    assign Fault     = (state_q == DONE) & fault_q;
    assign Busy      = (state_q != IDLE);

    // rw_q is kept for visibility of the in-flight request; the state encodes direction.
    logic unused_rw;
    assign unused_rw = rw_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural 256x32 RAM (one-cycle read latency).
module tb_data_mem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MFA;
    logic        ReadWrite;
    logic [1:0]  DataSize;
    logic        Signed;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataInHi;
    logic [31:0] DataOut;
    logic [31:0] DataOutHi;
    logic        MOC;
    logic        Fault;
    logic        Busy;
    logic        RamEnable;
    logic        RamReadWrite;
    logic [7:0]  RamAddress;
    logic [31:0] RamWrData;
    logic [31:0] RamRdData;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    data_mem_ctrl #(.RAM_WORDS(256)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .MFA(MFA),
        .ReadWrite(ReadWrite),
        .DataSize(DataSize),
        .Signed(Signed),
        .Address(Address),
        .DataIn(DataIn),
        .DataInHi(DataInHi),
        .DataOut(DataOut),
        .DataOutHi(DataOutHi),
        .MOC(MOC),
        .Fault(Fault),
        .Busy(Busy),
        .RamEnable(RamEnable),
        .RamReadWrite(RamReadWrite),
        .RamAddress(RamAddress),
        .RamWrData(RamWrData),
        .RamRdData(RamRdData)
    );

    always #5 Clk = ~Clk;

    logic [31:0] ram [256];
    always @(posedge Clk) begin
        if (RamEnable) begin
            if (RamReadWrite) ram[RamAddress] <= RamWrData;
            else              RamRdData <= ram[RamAddress];
        end
    end

    int total = 0;
    int bad = 0;

    int          moc_cyc;
    int          en_cnt;
    logic        flt_seen;
    logic        busy1;
    logic [31:0] dout_m;
    logic [31:0] douthi_m;
    logic [7:0]  en_addr [4];
    logic        en_wr [4];
    logic [31:0] en_wd [4];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, then track RAM activity cycle by cycle until MOC (cycle 1 = first after acceptance).
    task automatic do_req(input logic rw, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] din, input logic [31:0] dinhi);
        @(negedge Clk);
        ReadWrite = rw;
        DataSize  = sz;
        Signed    = sg;
        Address   = addr;
        DataIn    = din;
        DataInHi  = dinhi;
        MFA       = 1'b1;
        @(posedge Clk);
        #1;
        MFA      = 1'b0;
        moc_cyc  = 0;
        en_cnt   = 0;
        flt_seen = 1'b0;
        busy1    = Busy;
        for (int n = 1; n <= 12; n++) begin
            if (RamEnable) begin
                if (en_cnt < 4) begin
                    en_addr[en_cnt] = RamAddress;
                    en_wr[en_cnt]   = RamReadWrite;
                    en_wd[en_cnt]   = RamWrData;
                end
                en_cnt++;
            end
            if (MOC) begin
                moc_cyc  = n;
                flt_seen = Fault;
                dout_m   = DataOut;
                douthi_m = DataOutHi;
                break;
            end
            @(posedge Clk);
            #1;
        end
        @(posedge Clk);
        #1;
    endtask

    int          b2b_cnt;
    int          b2b_cyc [2];
    logic [31:0] b2b_dout [2];
    logic        busy4;
    logic [7:0]  addr5;

    initial begin
        Reset = 1'b0; MFA = 1'b0; ReadWrite = 1'b0; DataSize = SZ_B; Signed = 1'b0;
        Address = 32'd0; DataIn = 32'd0; DataInHi = 32'd0;
        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_ctl", {MOC, Fault, Busy, RamEnable, RamReadWrite}, 5'b0);
        check_val("rst_dout", {DataOutHi, DataOut}, 64'd0);
        check_val("rst_ram", {RamAddress, RamWrData}, 40'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // word store then load
        do_req(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
        check_val("wst_moc", moc_cyc, 2);
        check_val("wst_flt", flt_seen, 0);
        check_val("wst_busy1", busy1, 1);
        check_val("wst_en", en_cnt, 1);
        check_val("wst_acc", {en_wr[0], en_addr[0], en_wd[0]}, {1'b1, 8'd4, 32'hDEADBEEF});
        check_val("wst_ram", ram[4], 32'hDEADBEEF);

        do_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0);
        check_val("wld_moc", moc_cyc, 3);
        check_val("wld_acc", {en_cnt[7:0], en_wr[0], en_addr[0]}, {8'd1, 1'b0, 8'd4});
        check_val("wld_dout", dout_m, 32'hDEADBEEF);

        // byte read-modify-write
        do_req(1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, 32'h0);
        do_req(1'b1, SZ_B, 1'b0, 32'h22, 32'h555555AB, 32'h0);
        check_val("bst_moc", moc_cyc, 4);
        check_val("bst_en", en_cnt, 2);
        check_val("bst_acc0", {en_wr[0], en_addr[0]}, {1'b0, 8'd8});
        check_val("bst_acc1", {en_wr[1], en_addr[1], en_wd[1]}, {1'b1, 8'd8, 32'h11AB3344});
        check_val("bst_ram", ram[8], 32'h11AB3344);

        do_req(1'b0, SZ_B, 1'b1, 32'h22, 32'h0, 32'h0);
        check_val("bld_s_moc", moc_cyc, 3);
        check_val("bld_s", dout_m, 32'hFFFFFFAB);
        do_req(1'b0, SZ_B, 1'b0, 32'h22, 32'h0, 32'h0);
        check_val("bld_u", dout_m, 32'h000000AB);

        do_req(1'b1, SZ_H, 1'b0, 32'h20, 32'h1234BEEF, 32'h0);
        check_val("hst_moc", moc_cyc, 4);
        check_val("hst_ram", ram[8], 32'h11ABBEEF);
        do_req(1'b0, SZ_H, 1'b1, 32'h20, 32'h0, 32'h0);
        check_val("hld_s_lo", dout_m, 32'hFFFFBEEF);
        do_req(1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 32'h0);
        check_val("hld_s_hi", dout_m, 32'h000011AB);
        do_req(1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 32'h0);
        check_val("bld_lane3", dout_m, 32'h00000011);

        // doubleword
        do_req(1'b1, SZ_D, 1'b0, 32'h40, 32'h01234567, 32'h89ABCDEF);
        check_val("dst_moc", moc_cyc, 3);
        check_val("dst_en", en_cnt, 2);
        check_val("dst_acc0", {en_wr[0], en_addr[0], en_wd[0]}, {1'b1, 8'd16, 32'h01234567});
        check_val("dst_acc1", {en_wr[1], en_addr[1], en_wd[1]}, {1'b1, 8'd17, 32'h89ABCDEF});
        do_req(1'b0, SZ_D, 1'b0, 32'h40, 32'h0, 32'h0);
        check_val("dld_moc", moc_cyc, 4);
        check_val("dld_addr", {en_cnt[7:0], en_addr[0], en_addr[1]}, {8'd2, 8'd16, 8'd17});
        check_val("dld_data", {douthi_m, dout_m}, {32'h89ABCDEF, 32'h01234567});

        // rejected requests
        do_req(1'b0, SZ_H, 1'b0, 32'h3, 32'h0, 32'h0);
        check_val("f_half", {moc_cyc[7:0], flt_seen, busy1, en_cnt[7:0]}, {8'd1, 1'b1, 1'b1, 8'd0});
        check_val("f_half_d", {douthi_m, dout_m}, {32'h89ABCDEF, 32'h01234567});
        do_req(1'b0, SZ_W, 1'b0, 32'h402, 32'h0, 32'h0);
        check_val("f_word", {moc_cyc[7:0], flt_seen, en_cnt[7:0]}, {8'd1, 1'b1, 8'd0});
        check_val("f_word_d", {douthi_m, dout_m}, {32'h89ABCDEF, 32'h01234567});
        do_req(1'b0, SZ_D, 1'b0, 32'h3FC, 32'h0, 32'h0);
        check_val("f_dw255", {moc_cyc[7:0], flt_seen, en_cnt[7:0]}, {8'd1, 1'b1, 8'd0});
        check_val("f_dw255_d", {douthi_m, dout_m}, {32'h89ABCDEF, 32'h01234567});
        do_req(1'b1, SZ_W, 1'b0, 32'h400, 32'h77777777, 32'h0);
        check_val("f_wst_rng", {moc_cyc[7:0], flt_seen, en_cnt[7:0]}, {8'd1, 1'b1, 8'd0});

        // back-to-back word loads with MFA held high
        @(negedge Clk);
        ReadWrite = 1'b0; DataSize = SZ_W; Signed = 1'b0; Address = 32'h10; MFA = 1'b1;
        @(posedge Clk);
        #1;
        Address = 32'h40;
        b2b_cnt = 0; busy4 = 1'b1; addr5 = 8'hFF;
        for (int n = 1; n <= 12; n++) begin
            if (MOC) begin
                if (b2b_cnt < 2) begin
                    b2b_cyc[b2b_cnt]  = n;
                    b2b_dout[b2b_cnt] = DataOut;
                end
                b2b_cnt++;
            end
            if (n == 4) busy4 = Busy;
            if (n == 5) begin
                if (RamEnable) addr5 = RamAddress;
                MFA = 1'b0;
            end
            @(posedge Clk);
            #1;
        end
        check_val("b2b_cnt", b2b_cnt, 2);
        check_val("b2b_cyc", {b2b_cyc[0][7:0], b2b_cyc[1][7:0]}, {8'd3, 8'd7});
        check_val("b2b_gap", {busy4, addr5}, {1'b0, 8'd16});
        check_val("b2b_dout", {b2b_dout[0], b2b_dout[1]}, {32'hDEADBEEF, 32'h01234567});
        check_val("b2b_hi", DataOutHi, 32'h89ABCDEF);

        // reset in cycle 2 of a byte store
        @(negedge Clk);
        ReadWrite = 1'b1; DataSize = SZ_B; Address = 32'h21; DataIn = 32'h000000CD; MFA = 1'b1;
        @(posedge Clk);
        #1;
        MFA = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check_val("rmo_en", RamEnable, 0);
        @(posedge Clk);
        #1;
        check_val("rmo_ctl", {MOC, Fault, Busy, RamEnable, RamReadWrite}, 5'b0);
        check_val("rmo_dout", {DataOutHi, DataOut}, 64'd0);
        check_val("rmo_ram", {RamAddress, RamWrData}, 40'd0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_val("rmo_busy", {Busy, MOC}, 2'b00);
        check_val("rmo_word", ram[8], 32'h11ABBEEF);

        // reset during the write cycle of a word store must block the write
        @(negedge Clk);
        ReadWrite = 1'b1; DataSize = SZ_W; Address = 32'h10; DataIn = 32'h99999999; MFA = 1'b1;
        @(posedge Clk);
        #1;
        MFA = 1'b0;
        Reset = 1'b0;
        #1;
        check_val("rwr_gate", RamEnable, 0);
        @(posedge Clk);
        #1;
        check_val("rwr_ram", ram[4], 32'hDEADBEEF);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        do_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0);
        check_val("post_rst_ld", {moc_cyc[7:0], dout_m}, {8'd3, 32'hDEADBEEF});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Sequencing controller between the CPU control unit and the 256x32 word-addressed data RAM. Accepts one load/store request at a time (byte, halfword, word, doubleword) and converts it into single-cycle RAM accesses. Performs byte-lane extraction with optional sign extension on loads and read-modify-write on sub-word stores. Completion is signalled with a one-cycle MOC pulse.

## Interface
Parameters:
- RAM_WORDS, 256: RAM depth in 32-bit words; word index width is 8.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-low.
- MFA  in  1  memory function activate; request valid, sampled only in IDLE.
- ReadWrite  in  1  0 = load, 1 = store.
- DataSize  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- Signed  in  1  sign-extend byte/halfword loads.
- Address  in  32  byte address.
- DataIn  in  32  store data; low word for doubleword.
- DataInHi  in  32  doubleword high word.
- DataOut  out  32  load result; low word for doubleword.
- DataOutHi  out  32  doubleword load high word.
- MOC  out  1  memory operation complete, one-cycle pulse.
- Fault  out  1  valid with MOC; 1 = request rejected.
- Busy  out  1  request in flight.
- RamEnable  out  1  RAM access this cycle.
- RamReadWrite  out  1  0 read, 1 write.
- RamAddress  out  8  word index.
- RamWrData  out  32  data to RAM.
- RamRdData  in  32  RAM read data, valid the cycle after a read-enable cycle.

## Operation
- States: IDLE, RD0, RD1, CAP, RMW_RD, RMW_MRG, WR0, WR1, DONE.
- In IDLE with MFA=1: latch all request inputs, set Busy, and check the fault conditions:
  - Misalignment: halfword with Address[0]=1; word or doubleword with Address[1:0]!=0.
  - Out of range: Address[31:10]!=0.
  - Doubleword with word index 255; no wrap to 0.
- Fault -> DONE with Fault=1. No RAM access; DataOut/DataOutHi unchanged.
- Word index A = Address[9:2]; byte lane = Address[1:0], little-endian (lane 0 = bits 7:0); halfword lane = Address[1].
- Word load: RD0 (read A) -> CAP -> DONE.
- Doubleword load: RD0 (read A) -> RD1 (read A+1, capture low) -> CAP (capture high) -> DONE.
- Byte/halfword load: the lane is shifted to bit 0 and the upper bits are zero-filled, or sign-filled when Signed=1.
- Word store: WR0 (write A) -> DONE.
- Doubleword store: WR0 (write A, DataIn) -> WR1 (write A+1, DataInHi) -> DONE.
- Byte/halfword store: RMW_RD (read A) -> RMW_MRG (merge DataIn low bits into the lane) -> WR0 (write merged word) -> DONE. Other lanes are preserved.
- DONE: MOC=1 for one cycle, Busy still 1 -> IDLE.
- DataOut/DataOutHi hold until the next successful load; stores and faults never change them. For a doubleword load, DataOutHi is updated; for other loads it is unchanged.
- MFA is ignored while Busy. If MFA is still high in the IDLE cycle after DONE, a new request is accepted (level-sensitive).
- Signed and DataInHi are ignored where not applicable.

## Timing
- Acceptance at rising edge E0 (IDLE, MFA=1). Cycle n is the cycle after edge En-1.
- Word load: RAM read in cycle 1; MOC and DataOut valid in cycle 3.
- Doubleword load: reads in cycles 1–2; MOC in cycle 4.
- Word store: write in cycle 1; MOC in cycle 2.
- Doubleword store: writes in cycles 1–2; MOC in cycle 3.
- Byte/halfword store: read in cycle 1, merge in cycle 2, write in cycle 3; MOC in cycle 4.
- Fault: MOC=Fault=1 in cycle 1.
- Busy is 1 from cycle 1 through the MOC cycle inclusive. Minimum gap between MOCs is one IDLE cycle.
- RamEnable/RamReadWrite/RamAddress/RamWrData are decoded from the state register. RamEnable is forced to 0 in any cycle with Reset=0, so no RAM write can occur under reset.
- Reset (Reset=0 at an edge): state -> IDLE and the in-flight request is abandoned. A doubleword store may be left half-written; that is permitted.
- Reset values: DataOut=0, DataOutHi=0, MOC=0, Fault=0, Busy=0, RamEnable=0, RamReadWrite=0, RamAddress=0, RamWrData=0.

## Test plan
- Word store then load: store 0xDEADBEEF at Address 0x10, then load word at 0x10. Required: MOC in cycles 2 and 3 respectively; DataOut=0xDEADBEEF; RamAddress=4.
- Byte RMW: word 0x11223344 at 0x20; store byte 0xAB to 0x22. Required: RAM word becomes 0x11AB3344. Signed byte load of 0x22 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Doubleword: store Lo=0x01234567, Hi=0x89ABCDEF at 0x40, then load doubleword. Required: DataOut=0x01234567, DataOutHi=0x89ABCDEF; MOC in cycle 3 (store) and cycle 4 (load); RAM indices 16 and 17.
- Faults: halfword load at 0x3; word load at 0x402; doubleword load at 0x3FC. Required: each gives MOC=Fault=1 in cycle 1, no RamEnable, DataOut unchanged.
- Back-to-back: MFA held high across two word loads. Required: the second request is accepted in the IDLE cycle after the first MOC; no request is lost or duplicated.
- Reset mid-op: assert Reset=0 in cycle 2 of a byte store. Required: RamEnable=0 in that cycle, the RAM word is unchanged, all outputs are at their reset values, and Busy=0 after reset is released.
